// File: rtl/scoreboard_controller.sv
// Basketball-style scoreboard: two team scores, period game clock, shot clock and buzzers.
// Four-state controller (PAUSE/RUN/PERIOD_END/GAME_OVER); fsm_state mirrors the state register for checkers.
module scoreboard_controller #(
  parameter int SCORE_W       = 8,
  parameter int PERIOD_MIN    = 12,
  parameter int NUM_PERIODS   = 4,
  parameter int SHOT_SEC      = 24,
  parameter int TICKS_PER_SEC = 1000
) (
  input  logic               clock,
  input  logic               PB0,
  input  logic               PB1,
  input  logic               PB2,
  input  logic               PB3,
  input  logic               PB4,
  input  logic               PB5,
  input  logic [1:0]         pts,
  input  logic               SW1,
  input  logic               SW2,
  input  logic               SW3,
  input  logic               SW4,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2,
  output logic [3:0]         minutes,
  output logic [5:0]         seconds,
  output logic [4:0]         shotclock,
  output logic [2:0]         period,
  output logic               shot_buzzer,
  output logic               game_buzzer,
  output logic               game_over,
  output logic [1:0]         fsm_state
);

  typedef enum logic [1:0] {PAUSE = 2'd0, RUN = 2'd1, PERIOD_END = 2'd2, GAME_OVER = 2'd3} state_t;

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);
  localparam logic [3:0] MIN_RELOAD  = 4'(PERIOD_MIN);
  localparam logic [4:0] SHOT_RELOAD = 5'(SHOT_SEC);

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q;
  logic [4:0]    pb_hist;
  logic [4:0]    pb_edge;
  logic          clock_load, sec_tick, expire, next_period;
  logic [3:0]    min_n;
  logic [5:0]    sec_n;

  // Bit order: {PB5, PB4, PB3, PB2, PB1}
  assign pb_edge     = {PB5, PB4, PB3, PB2, PB1} & ~pb_hist;
  assign clock_load  = SW1 && (state_q == PAUSE || state_q == RUN);
  assign sec_tick    = (state_q == RUN) && (presc_q == PRESC_MAX) && !clock_load;
  assign next_period = (state_q == PERIOD_END) && pb_edge[4];

  always_comb begin
    min_n = minutes;
    sec_n = seconds;
    if (seconds != 6'd0) begin
      sec_n = seconds - 6'd1;
    end else if (minutes != 4'd0) begin
      min_n = minutes - 4'd1;
      sec_n = 6'd59;
    end
  end

  // Expiry only fires on the tick that actually moves the clock onto 0:00.
  assign expire = sec_tick && (min_n == 4'd0) && (sec_n == 6'd0) &&
                  !((minutes == 4'd0) && (seconds == 6'd0));

  always_comb begin
    state_d = state_q;
    case (state_q)
      PAUSE:      if (SW2) state_d = RUN;
      RUN: begin
        if (expire) state_d = (period >= 3'(NUM_PERIODS)) ? GAME_OVER : PERIOD_END;
        else if (!SW2) state_d = PAUSE;
      end
      PERIOD_END: if (pb_edge[4]) state_d = PAUSE;
      GAME_OVER:  state_d = GAME_OVER;
      default:    state_d = PAUSE;
    endcase
  end

  function automatic logic [SCORE_W-1:0] adjust(input logic [SCORE_W-1:0] s,
                                                input logic add, input logic sub,
                                                input logic [1:0] p);
    logic [SCORE_W+1:0] amt, wide;
    amt  = (SCORE_W+2)'((p == 2'd0) ? 2'd1 : p);
    wide = {2'b00, s};
    if (add && !sub) begin
      wide = wide + amt;
      if (wide > {2'b00, {SCORE_W{1'b1}}}) wide = {2'b00, {SCORE_W{1'b1}}};
    end else if (sub && !add) begin
      wide = (wide < amt) ? '0 : wide - amt;
    end
    return wide[SCORE_W-1:0];
  endfunction

  always_ff @(posedge clock) begin
    if (PB0) begin
      state_q     <= PAUSE;
      presc_q     <= '0;
      pb_hist     <= '0;
      score1      <= '0;
      score2      <= '0;
      minutes     <= MIN_RELOAD;
      seconds     <= 6'd0;
      shotclock   <= SHOT_RELOAD;
      period      <= 3'd1;
      shot_buzzer <= 1'b0;
      game_buzzer <= 1'b0;
    end else begin
      state_q     <= state_d;
      pb_hist     <= {PB5, PB4, PB3, PB2, PB1};
      shot_buzzer <= 1'b0;
      game_buzzer <= 1'b0;

      if (state_q != GAME_OVER) begin
        score1 <= adjust(score1, pb_edge[0], pb_edge[1], pts);
        score2 <= adjust(score2, pb_edge[2], pb_edge[3], pts);
      end

      // Prescaler holds its count outside RUN so a pause resumes mid-second.
      if (clock_load) presc_q <= '0;
      else if (state_q == RUN) presc_q <= (presc_q == PRESC_MAX) ? '0 : presc_q + PW'(1);

      if (clock_load) begin
        minutes <= MIN_RELOAD;
        seconds <= 6'd0;
      end else if (next_period) begin
        period  <= period + 3'd1;
        minutes <= MIN_RELOAD;
        seconds <= 6'd0;
      end else if (sec_tick) begin
        minutes     <= min_n;
        seconds     <= sec_n;
        game_buzzer <= expire;
      end

      if (clock_load || next_period || (SW3 && state_q != GAME_OVER)) begin
        shotclock <= SHOT_RELOAD;
      end else if (sec_tick && SW4 && shotclock != 5'd0) begin
        shotclock   <= shotclock - 5'd1;
        shot_buzzer <= (shotclock == 5'd1);
      end
    end
  end

  assign game_over = (state_q == GAME_OVER);
  assign fsm_state = state_q;

endmodule

// File: tb/tb_scoreboard_controller.sv
// Directed scoreboard bench for scoreboard_controller (TICKS_PER_SEC=2, PERIOD_MIN=1, SHOT_SEC=3, NUM_PERIODS=2).
// Driver pushes expectations after each active edge; a negedge monitor pops and compares them.
module tb_scoreboard_controller;

  localparam int SCORE_W = 8;
  localparam int S1 = 0, S2 = 1, MIN = 2, SEC = 3, SHOT = 4, PER = 5, GO = 6, ST = 7;
  localparam int SBZ = 8, GBZ = 9, SBC = 10, GBC = 11;
  localparam int ST_PAUSE = 0, ST_RUN = 1, ST_PEND = 2, ST_GOVER = 3;

  logic clock = 1'b0;
  logic PB0 = 1'b1, PB1 = 1'b0, PB2 = 1'b0, PB3 = 1'b0, PB4 = 1'b0, PB5 = 1'b0;
  logic [1:0] pts = 2'd0;
  logic SW1 = 1'b0, SW2 = 1'b0, SW3 = 1'b0, SW4 = 1'b0;
  logic [SCORE_W-1:0] score1, score2;
  logic [3:0] minutes;
  logic [5:0] seconds;
  logic [4:0] shotclock;
  logic [2:0] period;
  logic shot_buzzer, game_buzzer, game_over;
  logic [1:0] fsm_state;

  logic [15:0] exp_q[$];
  int          sel_q[$];
  string       name_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int sb_cnt = 0;
  int gb_cnt = 0;

  scoreboard_controller #(
    .SCORE_W(SCORE_W), .PERIOD_MIN(1), .NUM_PERIODS(2), .SHOT_SEC(3), .TICKS_PER_SEC(2)
  ) dut (
    .clock(clock), .PB0(PB0), .PB1(PB1), .PB2(PB2), .PB3(PB3), .PB4(PB4), .PB5(PB5),
    .pts(pts), .SW1(SW1), .SW2(SW2), .SW3(SW3), .SW4(SW4),
    .score1(score1), .score2(score2), .minutes(minutes), .seconds(seconds),
    .shotclock(shotclock), .period(period), .shot_buzzer(shot_buzzer),
    .game_buzzer(game_buzzer), .game_over(game_over), .fsm_state(fsm_state)
  );

  // Clock/reset
  always #5 clock = ~clock;

  function automatic logic [15:0] pick(input int sel);
    case (sel)
      S1:   return 16'(score1);
      S2:   return 16'(score2);
      MIN:  return 16'(minutes);
      SEC:  return 16'(seconds);
      SHOT: return 16'(shotclock);
      PER:  return 16'(period);
      GO:   return 16'(game_over);
      ST:   return 16'(fsm_state);
      SBZ:  return 16'(shot_buzzer);
      GBZ:  return 16'(game_buzzer);
      SBC:  return 16'(sb_cnt);
      GBC:  return 16'(gb_cnt);
      default: return 16'hxxxx;
    endcase
  endfunction

  // Monitor: count buzzer pulses, then drain and compare pending expectations.
  always @(negedge clock) begin
    if (shot_buzzer === 1'b1) sb_cnt++;
    if (game_buzzer === 1'b1) gb_cnt++;
    while (exp_q.size() > 0) begin
      logic [15:0] e, g;
      int s;
      string nm;
      e  = exp_q.pop_front();
      s  = sel_q.pop_front();
      nm = name_q.pop_front();
      g  = pick(s);
      n_cmp++;
      if (g !== e) begin
        n_err++;
        $display("FAIL %s: got %0d expected %0d", nm, g, e);
      end
    end
  end

  // Driver tasks
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic ex(input string nm, input int sel, input int v);
    exp_q.push_back(16'(v));
    sel_q.push_back(sel);
    name_q.push_back(nm);
  endtask

  task automatic check_reset(input string tag);
    ex({tag, "_score1"}, S1, 0);
    ex({tag, "_score2"}, S2, 0);
    ex({tag, "_minutes"}, MIN, 1);
    ex({tag, "_seconds"}, SEC, 0);
    ex({tag, "_shot"}, SHOT, 3);
    ex({tag, "_period"}, PER, 1);
    ex({tag, "_game_over"}, GO, 0);
    ex({tag, "_state"}, ST, ST_PAUSE);
    ex({tag, "_shot_buzzer"}, SBZ, 0);
    ex({tag, "_game_buzzer"}, GBZ, 0);
  endtask

  initial begin
    tick(1);
    PB0 = 1'b0;
    check_reset("por");

    // Score edits: held add counts once, subtract saturates at zero
    pts = 2'd3; PB1 = 1'b1;
    tick(5); ex("add_held", S1, 3);
    PB1 = 1'b0; pts = 2'd2; PB2 = 1'b1;
    tick(1); ex("sub_2", S1, 1);
    PB2 = 1'b0; tick(1);
    PB2 = 1'b1;
    tick(1); ex("sub_sat0", S1, 0);
    PB2 = 1'b0;
    pts = 2'd0; PB3 = 1'b1;
    tick(1); ex("pts0_is_1", S2, 1);
    PB3 = 1'b0; tick(1);
    pts = 2'd3;
    for (int i = 0; i < 90; i++) begin
      PB3 = 1'b1; tick(1);
      PB3 = 1'b0; tick(1);
    end
    ex("add_sat_max", S2, 255);
    pts = 2'd1; PB4 = 1'b1;
    tick(1); ex("sub_from_max", S2, 254);
    PB4 = 1'b0;

    // Shot clock countdown and reload
    SW4 = 1'b1; SW2 = 1'b1;
    tick(1); ex("run_entry", ST, ST_RUN); ex("shot_start", SHOT, 3);
    tick(2); ex("shot_2", SHOT, 2); ex("clk_059_min", MIN, 0); ex("clk_059_sec", SEC, 59);
    tick(2); ex("shot_1", SHOT, 1);
    tick(2); ex("shot_0", SHOT, 0); ex("shot_buzz_on", SBZ, 1); ex("sec_57", SEC, 57);
    tick(2); ex("shot_hold0", SHOT, 0); ex("shot_buzz_off", SBZ, 0); ex("shot_buzz_once", SBC, 1);
    SW3 = 1'b1;
    tick(1); ex("shot_reload", SHOT, 3);
    SW3 = 1'b0; SW4 = 1'b0;

    // Reset mid-RUN
    PB0 = 1'b1;
    tick(1);
    PB0 = 1'b0;
    check_reset("run_reset");

    // Full period countdown
    tick(1); ex("p1_run", ST, ST_RUN); ex("p1_min", MIN, 1); ex("p1_sec", SEC, 0);
    tick(2); ex("p1_059_min", MIN, 0); ex("p1_059_sec", SEC, 59);
    tick(117); ex("p1_001_sec", SEC, 1); ex("p1_001_state", ST, ST_RUN);
    tick(1);
    ex("p1_end_min", MIN, 0); ex("p1_end_sec", SEC, 0);
    ex("p1_end_state", ST, ST_PEND); ex("p1_game_buzz", GBZ, 1); ex("p1_not_over", GO, 0);
    tick(1); ex("p1_buzz_off", GBZ, 0); ex("p1_buzz_once", GBC, 1);
    SW2 = 1'b0; tick(1);
    SW2 = 1'b1; tick(1);
    SW2 = 1'b0; tick(1);
    ex("pend_sw2_ignored", ST, ST_PEND); ex("pend_sec", SEC, 0);
    SW1 = 1'b1;
    tick(1); ex("pend_sw1_ignored", MIN, 0);
    SW1 = 1'b0; pts = 2'd2; PB1 = 1'b1;
    tick(1); ex("pend_score_edit", S1, 2);
    PB1 = 1'b0;

    // Next period leaves via PAUSE even with SW2 high
    SW2 = 1'b1; PB5 = 1'b1;
    tick(1);
    ex("p2_period", PER, 2); ex("p2_min", MIN, 1); ex("p2_sec", SEC, 0);
    ex("p2_shot", SHOT, 3); ex("p2_pause", ST, ST_PAUSE);
    tick(1); ex("p2_run", ST, ST_RUN); ex("p2_held_pb5", PER, 2);
    PB5 = 1'b0; tick(1);
    PB5 = 1'b1; tick(1);
    ex("pb5_in_run_ignored", PER, 2); ex("p2_059", SEC, 59);
    PB5 = 1'b0;
    tick(117); ex("p2_001_sec", SEC, 1); ex("p2_001_go", GO, 0);
    tick(1);
    ex("final_go", GO, 1); ex("final_state", ST, ST_GOVER); ex("final_buzz", GBZ, 1);
    ex("final_min", MIN, 0); ex("final_sec", SEC, 0);
    PB1 = 1'b1;
    tick(1); ex("gover_score_ignored", S1, 2); ex("gover_buzz_count", GBC, 2);
    PB1 = 1'b0;
    tick(3); ex("gover_frozen_sec", SEC, 0); ex("gover_frozen_state", ST, ST_GOVER);

    // Reset from GAME_OVER, then simultaneous presses
    PB0 = 1'b1;
    tick(1);
    PB0 = 1'b0; SW2 = 1'b0;
    check_reset("go_reset");
    pts = 2'd3; PB1 = 1'b1;
    tick(1); ex("post_reset_add", S1, 3);
    PB1 = 1'b0; tick(1);
    PB1 = 1'b1; PB2 = 1'b1; PB3 = 1'b1;
    tick(1); ex("simul_unchanged", S1, 3); ex("team2_independent", S2, 3);
    PB1 = 1'b0; PB2 = 1'b0; PB3 = 1'b0;
    tick(2);

    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
